rf_wbck_ctrl: RTL
=================

# rf_wbck_ctrl

Writeback controller for the general register file. It arbitrates two writeback requesters (ALU/EXU and LSU load return) onto the single register-file write port using round-robin priority. It also keeps a per-register busy scoreboard that stalls dispatch on RAW/WAW hazards against in-flight writes. It sits between EXU/LSU and the register file write port (`wbck_dest_wen/idx/dat`), and feeds the IDU stall logic.

## Interface
- `XLEN`, 32, data width (from `defines.v`)
- `RFIDX_WIDTH`, 5, register index width
- `RFREG_NUM`, 32, number of architectural registers (x0 included)

- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `alu_wb_valid` in 1: ALU writeback request
- `alu_wb_ready` out 1: ALU request granted this cycle
- `alu_wb_idx` in RFIDX_WIDTH: ALU destination register
- `alu_wb_dat` in XLEN: ALU result
- `lsu_wb_valid` / `lsu_wb_ready` / `lsu_wb_idx` / `lsu_wb_dat`: same as ALU, for load data
- `disp_valid` in 1: IDU presents an instruction for dispatch
- `disp_rd_wen` in 1: instruction writes rd
- `disp_rd_idx`, `disp_rs1_idx`, `disp_rs2_idx` in RFIDX_WIDTH: operand indices
- `disp_stall` out 1: hazard; dispatch must not fire
- `wbck_dest_wen` out 1: register file write enable
- `wbck_dest_idx` out RFIDX_WIDTH: register file write index
- `wbck_dest_dat` out XLEN: register file write data
- `sb_busy` out RFREG_NUM: scoreboard vector (debug and DPI visibility)
- `wb_err` out 1: sticky flag; a writeback targeted a non-busy register

## Operation
- Handshake: a request transfers when `*_valid & *_ready`. `ready` is combinational from both valids and the pointer. Requesters hold idx and dat stable until they see ready.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - The `last_grant` register updates only on a transfer. At reset it is LSU, so the ALU wins the first tie.
  - There is at most one grant per cycle. The write port never back-pressures, so a sole requester is always ready.
- Output stage: the granted idx and dat are registered into `wbck_dest_*`. `wbck_dest_wen` is 1 for one cycle per transfer. A transfer with idx 0 is accepted with `wbck_dest_wen=0`.
- Scoreboard, set: on `disp_valid & ~disp_stall & disp_rd_wen & rd!=0`, set `busy[rd]`.
- Scoreboard, clear: on each cycle with `wbck_dest_wen=1`, clear `busy[wbck_dest_idx]` at that edge.
- `busy[0]` is always 0.
- Stall: `disp_stall = disp_valid & (busy[rs1] | busy[rs2] | (disp_rd_wen & busy[rd]))`. It uses the registered busy only, with no bypass.
- Simultaneous set and clear of the same index cannot occur, because the WAW stall blocks the set. If it does occur, set wins.
- `wb_err` is set when a transfer with idx≠0 targets a register with `busy[idx]=0`. It is cleared only by reset.

## Timing
- Reset values: `wbck_dest_wen=0`, `wbck_dest_idx=0`, `wbck_dest_dat=0`, `sb_busy=0`, `wb_err=0`, `last_grant=LSU`. Ready outputs follow the valids combinationally, even in the reset cycle.
- Reset mid-operation: in-flight output-stage writes are dropped (wen forced 0 the next cycle) and busy is cleared.
- Latency from transfer edge:
  - Cycle N: transfer.
  - Cycle N+1: `wbck_dest_wen=1`. The RF captures at the end of N+1, and busy clears at the same edge.
  - Cycle N+2: a dependent dispatch sees `disp_stall=0` and reads the new value.
- Throughput: one writeback per cycle. Under continuous contention the grants alternate ALU and LSU.

## Structure
- Shared package (`defines.v` extension):
  - `WB_SRC_ALU=1'b0`, `WB_SRC_LSU=1'b1`
  - the `XLEN`/`RFIDX_WIDTH`/`RFREG_NUM` macros
- Sub-module `rf_scoreboard`: busy vector, set/clear, stall compare and `wb_err`.
- Top level: arbiter, pointer and output register.

## Test plan
- Reset, then `alu_wb_valid=1`, idx=5, dat=0xDEADBEEF, with busy[5] pre-set via dispatch: `alu_wb_ready=1` in the same cycle. Next cycle `wbck_dest_wen=1`, idx=5, dat=0xDEADBEEF. `busy[5]` is 0 after that edge and `wb_err=0`.
- Both valid for 4 cycles (ALU idx 3, LSU idx 4, both busy): grants go ALU, LSU, ALU, LSU, and the output idx sequence is 3, 4, 3, 4 one cycle later.
- Dispatch rd=7, then dispatch with rs1=7: `disp_stall=1` until the cycle after `wbck_dest_wen` for idx 7, then 0.
- Dispatch with `disp_rd_wen=1`, rd=0: busy stays 0 and no stall. LSU writeback to idx 0 is accepted, `wbck_dest_wen=0`, and `wb_err=0`.
- Writeback to idx 9 with `busy[9]=0`: `wb_err=1` and it stays 1 until `rst`.
- Assert `rst` while busy[2]=1 and a transfer is in the output stage: the next cycle `wbck_dest_wen=0`, `sb_busy=0`, `wb_err=0`, and the first tie is granted to the ALU.

Source files
------------

// File: rtl/rf_wbck_ctrl_pkg.sv
// Shared writeback-path definitions: data/index widths, source encoding and
// the writeback request payload.
package rf_wbck_ctrl_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned RFIDX_WIDTH = 5;
    localparam int unsigned RFREG_NUM   = 32;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [RFIDX_WIDTH-1:0] idx;
        logic [XLEN-1:0]        dat;
    } wb_req_t;

    // One-hot register mask for a register index.
    function automatic logic [RFREG_NUM-1:0] idx_onehot(input logic [RFIDX_WIDTH-1:0] idx);
        return RFREG_NUM'(1) << idx;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: tracks in-flight writes, raises the dispatch
// stall on RAW/WAW hazards and flags writebacks to registers that are not busy.
module rf_scoreboard
    import rf_wbck_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   disp_valid,
    input  logic                   disp_rd_wen,
    input  logic [RFIDX_WIDTH-1:0] disp_rd_idx,
    input  logic [RFIDX_WIDTH-1:0] disp_rs1_idx,
    input  logic [RFIDX_WIDTH-1:0] disp_rs2_idx,
    input  logic                   clr_en,
    input  logic [RFIDX_WIDTH-1:0] clr_idx,
    input  logic                   xfer_en,
    input  logic [RFIDX_WIDTH-1:0] xfer_idx,
    output logic [RFREG_NUM-1:0]   busy,
    output logic                   disp_stall,
    output logic                   wb_err
);

    logic                 set_en;
    logic [RFREG_NUM-1:0] busy_nxt;
    logic                 wb_err_nxt;

    // Hazard check uses registered busy only; no writeback bypass.
    always_comb begin
        disp_stall = disp_valid & (busy[disp_rs1_idx] | busy[disp_rs2_idx] |
                                   (disp_rd_wen & busy[disp_rd_idx]));
        set_en     = disp_valid & ~disp_stall & disp_rd_wen & (disp_rd_idx != '0);
    end

    // Clear first so that a same-index set takes precedence; x0 never busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt = busy_nxt & ~idx_onehot(clr_idx);
        end
        if (set_en) begin
            busy_nxt = busy_nxt | idx_onehot(disp_rd_idx);
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        wb_err_nxt = wb_err | (xfer_en & (xfer_idx != '0) & ~busy[xfer_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            wb_err <= 1'b0;
        end else begin
            busy   <= busy_nxt;
            wb_err <= wb_err_nxt;
        end
    end

endmodule

// File: rtl/rf_wbck_ctrl.sv
// Register-file writeback controller: round-robin arbitration of ALU and LSU
// writebacks onto the single RF write port, plus the busy scoreboard.
module rf_wbck_ctrl
    import rf_wbck_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_wb_valid,
    output logic                   alu_wb_ready,
    input  logic [RFIDX_WIDTH-1:0] alu_wb_idx,
    input  logic [XLEN-1:0]        alu_wb_dat,
    input  logic                   lsu_wb_valid,
    output logic                   lsu_wb_ready,
    input  logic [RFIDX_WIDTH-1:0] lsu_wb_idx,
    input  logic [XLEN-1:0]        lsu_wb_dat,
    input  logic                   disp_valid,
    input  logic                   disp_rd_wen,
    input  logic [RFIDX_WIDTH-1:0] disp_rd_idx,
    input  logic [RFIDX_WIDTH-1:0] disp_rs1_idx,
    input  logic [RFIDX_WIDTH-1:0] disp_rs2_idx,
    output logic                   disp_stall,
    output logic                   wbck_dest_wen,
    output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
    output logic [XLEN-1:0]        wbck_dest_dat,
    output logic [RFREG_NUM-1:0]   sb_busy,
    output logic                   wb_err
);

    wb_src_e last_grant;
    wb_src_e last_grant_nxt;
    logic    xfer;
    wb_req_t xfer_req;

    // Grant pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= WB_SRC_LSU;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    // Pointer moves only on a transfer, to the source that was granted.
    always_comb begin
        last_grant_nxt = last_grant;
        if (alu_wb_ready) begin
            last_grant_nxt = WB_SRC_ALU;
        end else if (lsu_wb_ready) begin
            last_grant_nxt = WB_SRC_LSU;
        end
    end

    // Grant decode: a sole requester always wins, a tie goes to the other side.
    always_comb begin
        alu_wb_ready = alu_wb_valid & (~lsu_wb_valid | (last_grant == WB_SRC_LSU));
        lsu_wb_ready = lsu_wb_valid & (~alu_wb_valid | (last_grant == WB_SRC_ALU));
        xfer         = alu_wb_ready | lsu_wb_ready;
        xfer_req     = alu_wb_ready ? wb_req_t'{idx: alu_wb_idx, dat: alu_wb_dat}
                                    : wb_req_t'{idx: lsu_wb_idx, dat: lsu_wb_dat};
    end

    // Output stage; writes to x0 are accepted but never enable the RF port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbck_dest_wen <= 1'b0;
            wbck_dest_idx <= '0;
            wbck_dest_dat <= '0;
        end else begin
            wbck_dest_wen <= xfer & (xfer_req.idx != '0);
            if (xfer) begin
                wbck_dest_idx <= xfer_req.idx;
                wbck_dest_dat <= xfer_req.dat;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .disp_rd_wen  (disp_rd_wen),
        .disp_rd_idx  (disp_rd_idx),
        .disp_rs1_idx (disp_rs1_idx),
        .disp_rs2_idx (disp_rs2_idx),
        .clr_en       (wbck_dest_wen),
        .clr_idx      (wbck_dest_idx),
        .xfer_en      (xfer),
        .xfer_idx     (xfer_req.idx),
        .busy         (sb_busy),
        .disp_stall   (disp_stall),
        .wb_err       (wb_err)
    );

endmodule
